adc_capture: RTL
================

// Module: adc_capture
// PURPOSE
//  Drives the LTC1407A-1 dual 14-bit ADC on the shared SPI SCK: pulses AD_CONV, clocks 34 SCK
//  cycles and deserialises ADC_OUT into channel A/B samples. Sits beside Amp under the top level;
//  cntr issues adc_trig and consumes adc_done/adc_a/adc_b. Top muxes spi_sck with the Amp SCK.
// PARAMETERS
//  SCK_DIV    2  SCK half-period in CLK50MHZ cycles (2 -> 12.5 MHz SCK); legal >= 1
//  CONV_HIGH  2  AD_CONV high time in CLK50MHZ cycles; legal >= 1
// PORTS
//  CLK50MHZ  in   1   system clock, 50 MHz; the only clock
//  RST       in   1   reset, synchronous, active-high
//  adc_trig  in   1   start request; sampled only in IDLE
//  adc_done  out  1   one-cycle pulse: adc_a/adc_b updated this cycle
//  adc_a     out  14  channel A sample, two's complement, held until next adc_done
//  adc_b     out  14  channel B sample, two's complement, held until next adc_done
//  busy      out  1   high in every state except IDLE
//  ad_conv   out  1   to AD_CONV pin
//  spi_sck   out  1   SCK contribution; 0 whenever not in SHIFT
//  adc_out   in   1   from ADC_OUT pin
// BEHAVIOUR
//  Reset: state=IDLE; adc_done, busy, ad_conv, spi_sck = 0; adc_a, adc_b, shift regs,
//   counters = 0. RST mid-conversion aborts at the next edge; outputs return to reset values,
//   and no adc_done is issued for the aborted conversion.
//  FSM IDLE -> CONV -> SHIFT -> DONE -> IDLE.
//  IDLE: adc_trig=1 -> CONV on next edge. Otherwise stay.
//  CONV: ad_conv=1 for exactly CONV_HIGH cycles, spi_sck=0, then -> SHIFT.
//  SHIFT: 34 SCK periods; each period is SCK_DIV cycles low, then SCK_DIV cycles high.
//   SCK starts low.
//   - adc_out is sampled on the clock edge at which spi_sck goes 0->1.
//   - Rising edges numbered 1..34:
//     edges 3..16 shift channel A, MSB first (edge 3 = bit13).
//     edges 19..32 shift channel B, MSB first.
//     edges 1, 2, 17, 18, 33 and 34 are discarded.
//   - After the high phase of period 34, spi_sck returns to 0 and -> DONE.
//  DONE: one cycle. adc_a/adc_b are loaded from the shift regs, adc_done=1, then -> IDLE.
//  Latency: adc_done is high exactly 1+CONV_HIGH+68*SCK_DIV cycles after the edge on which
//   adc_trig was accepted (139 cycles with defaults).
//  adc_trig in CONV/SHIFT/DONE is ignored, not queued.
//  adc_trig held high continuously gives back-to-back conversions, with one IDLE cycle between.
//  Samples are copied verbatim; no sign extension, no gain applied.
//  Counters must not wrap mid-frame. The bit counter spans 0..34, the divider spans 0..SCK_DIV-1.
// TESTING
//  1 ADC model returns A=14'h1ABC, B=14'h0543; one trig -> adc_done after 139 cycles,
//    adc_a=14'h1ABC, adc_b=14'h0543, busy low on the next cycle.
//  2 Model returns A=14'h2000, B=14'h3FFF -> adc_a=14'h2000 (-8192), adc_b=14'h3FFF (-1).
//  3 Timing check: ad_conv high exactly 2 cycles; exactly 34 spi_sck rising edges; each phase
//    is 2 cycles; spi_sck=0 outside SHIFT.
//  4 Trig pulsed at cycles 10 and 60 after the first trig -> only one adc_done; the data is
//    from the first frame.
//  5 RST asserted for 1 cycle mid-SHIFT (edge 20) -> next cycle IDLE, all outputs 0, no
//    adc_done. A new trig then completes normally with correct data.
//  6 adc_trig held high 3 frames with A=1,2,3 -> three adc_done pulses 140 cycles apart,
//    adc_a=1,2,3 in order.

Source files
------------

// File: rtl/adc_capture_if.sv
// Signal bundle between the LTC1407A-1 capture block and its controller / ADC pins.
interface adc_capture_if;
    logic        adc_trig;
    logic        adc_done;
    logic [13:0] adc_a;
    logic [13:0] adc_b;
    logic        busy;
    logic        ad_conv;
    logic        spi_sck;
    logic        adc_out;

    modport master (
        input  adc_trig,
        input  adc_out,
        output adc_done,
        output adc_a,
        output adc_b,
        output busy,
        output ad_conv,
        output spi_sck
    );

    modport slave (
        output adc_trig,
        output adc_out,
        input  adc_done,
        input  adc_a,
        input  adc_b,
        input  busy,
        input  ad_conv,
        input  spi_sck
    );
endinterface

// File: rtl/adc_capture.sv
// LTC1407A-1 capture: pulses AD_CONV, clocks 34 SCK periods and deserialises
// ADC_OUT into 14-bit channel A and channel B samples.
module adc_capture #(
    parameter int SCK_DIV   = 2,
    parameter int CONV_HIGH = 2
) (
    input  logic          CLK50MHZ,
    input  logic          RST,
    adc_capture_if.master bus
);

    localparam int CONV_W = $clog2(CONV_HIGH) + 1;
    localparam int DIV_W  = $clog2(SCK_DIV) + 1;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        SHIFT,
        DONE
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [CONV_W-1:0] conv_cnt;
    logic [DIV_W-1:0]  div_cnt;
    logic              sck_high;
    logic [5:0]        edge_cnt;
    logic [5:0]        edge_num;
    logic [13:0]       shift_a;
    logic [13:0]       shift_b;
    logic [13:0]       adc_a_q;
    logic [13:0]       adc_b_q;
    logic              conv_last;
    logic              div_last;
    logic              sck_rise;
    logic              shift_last;

    assign conv_last  = (conv_cnt == CONV_W'(CONV_HIGH - 1));
    assign div_last   = (div_cnt == DIV_W'(SCK_DIV - 1));
    assign sck_rise   = (state == SHIFT) && div_last && !sck_high;
    assign edge_num   = edge_cnt + 6'd1;
    assign shift_last = div_last && sck_high && (edge_cnt == 6'd34);

    // State register; reset abandons any frame in progress.
    always_ff @(posedge CLK50MHZ) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: a trigger is only looked at in IDLE, so extra requests are dropped.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.adc_trig) state_next = CONV;
            CONV:    if (conv_last)    state_next = SHIFT;
            SHIFT:   if (shift_last)   state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Frame timing counters and deserialiser; data is taken on each SCK rising edge.
    always_ff @(posedge CLK50MHZ) begin
        if (RST) begin
            conv_cnt <= '0;
            div_cnt  <= '0;
            sck_high <= 1'b0;
            edge_cnt <= 6'd0;
            shift_a  <= 14'd0;
            shift_b  <= 14'd0;
            adc_a_q  <= 14'd0;
            adc_b_q  <= 14'd0;
        end else begin
            conv_cnt <= (state == CONV) ? conv_cnt + CONV_W'(1) : '0;
            if (state == SHIFT) begin
                if (div_last) begin
                    div_cnt  <= '0;
                    sck_high <= ~sck_high;
                end else begin
                    div_cnt <= div_cnt + DIV_W'(1);
                end
                if (sck_rise) begin
                    edge_cnt <= edge_num;
                    if (edge_num >= 6'd3 && edge_num <= 6'd16) begin
                        shift_a <= {shift_a[12:0], bus.adc_out};
                    end
                    if (edge_num >= 6'd19 && edge_num <= 6'd32) begin
                        shift_b <= {shift_b[12:0], bus.adc_out};
                    end
                end
                if (shift_last) begin
                    adc_a_q <= shift_a;
                    adc_b_q <= shift_b;
                end
            end else begin
                div_cnt  <= '0;
                sck_high <= 1'b0;
                edge_cnt <= 6'd0;
            end
        end
    end

    // Outputs decoded from state so they all fall to zero the cycle after reset.
    always_comb begin
        bus.busy     = (state != IDLE);
        bus.ad_conv  = (state == CONV);
        bus.spi_sck  = (state == SHIFT) && sck_high;
        bus.adc_done = (state == DONE);
        bus.adc_a    = adc_a_q;
        bus.adc_b    = adc_b_q;
    end

endmodule
